icache_refill_ctrl: RTL and testbench
=====================================

Name: icache_refill_ctrl

Overview:
- Drains the icache miss-request queue, one line address per entry, and fetches each missing line from the memory port as a fixed-length beat burst.
- Assembles the beats into one full line and presents it to the cache data/tag write port as a single-cycle write pulse.
- Sits directly downstream of the miss-request FIFO and handles one refill at a time.

Parameters:
- ADDR_W, 32, byte-address width of queue entries and memory requests.
- LINE_BYTES, 64, cache line size in bytes; power of two.
- BUS_W, 128, memory response data width in bits; power of two; LINE_BYTES*8 must be a multiple of BUS_W.
- Derived (localparam): LINE_W = LINE_BYTES*8; BEATS = LINE_W/BUS_W (default 4); OFS_W = log2(LINE_BYTES); BCNT_W = max(1, log2(BEATS)).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- q_empty  in  1  miss queue empty flag.
- q_rd_en  out  1  queue pop strobe; queue data is valid on q_data the cycle after the pop.
- q_data  in  ADDR_W  miss byte address from the queue.
- mem_req_valid  out  1  burst read request valid.
- mem_req_ready  in  1  memory accepts the request.
- mem_req_addr  out  ADDR_W  line-aligned burst address.
- mem_rsp_valid  in  1  response beat valid; no backpressure, always accepted.
- mem_rsp_data  in  BUS_W  beat data.
- mem_rsp_last  in  1  final beat marker.
- line_wr_valid  out  1  one-cycle line write pulse.
- line_wr_addr  out  ADDR_W  line-aligned address of the written line.
- line_wr_data  out  LINE_W  assembled line; beat i occupies bits [i*BUS_W +: BUS_W].
- busy  out  1  high in every state except IDLE.
- err_last  out  1  one-cycle pulse on a last-marker protocol error.

Behaviour:
- Reset: all outputs 0. FSM enters IDLE; beat_cnt=0; line buffer=0; last_line_vld=0.
- FSM states: IDLE, LATCH, REQ, BEAT, WRITE.
- IDLE:
  - if !q_empty: q_rd_en=1 for exactly one cycle, next state LATCH.
  - q_rd_en is never asserted in any other state, so at most one pop is outstanding.
- LATCH:
  - capture line_addr = {q_data[ADDR_W-1:OFS_W], OFS_W'b0}.
  - if last_line_vld && line_addr==last_line_addr: drop the entry (duplicate miss), next state IDLE, no memory request issued.
  - otherwise next state REQ.
- REQ:
  - mem_req_valid=1; mem_req_addr=line_addr, held stable until accepted.
  - on mem_req_valid && mem_req_ready: beat_cnt=0, next state BEAT.
- BEAT:
  - on mem_rsp_valid: write mem_rsp_data into buffer slot beat_cnt; beat_cnt increments.
  - beat_cnt==BEATS-1 with valid is the final beat: next state WRITE.
  - err_last pulses on the cycle after any beat whose mem_rsp_last differs from (beat_cnt==BEATS-1).
  - the FSM always completes on the beat count, never on mem_rsp_last.
  - beats arriving in any state other than BEAT are ignored.
- WRITE:
  - line_wr_valid=1 for one cycle; line_wr_addr=line_addr; line_wr_data=buffer.
  - set last_line_addr=line_addr and last_line_vld=1; next state IDLE.
  - line_wr_addr and line_wr_data hold their values after the pulse until the next WRITE.
- Latency:
  - q_rd_en in cycle t gives mem_req_valid at t+2 at the earliest.
  - final beat in cycle k gives line_wr_valid at k+1.
  - the next pop is at k+2 at the earliest.
- Simultaneous events:
  - request acceptance and a beat in the same cycle: that beat is ignored, because responses are only legal after acceptance.
  - q_empty going high during LATCH has no effect.
- Reset mid-operation: asynchronous return to IDLE with all outputs low. An in-flight burst is abandoned, and the memory side is reset by the same rst_n.
- Width rules:
  - beat_cnt is BCNT_W bits and wraps to 0 after the final beat.
  - address bits [OFS_W-1:0] are always zero on both mem_req_addr and line_wr_addr.

Test Plan:
- Single miss:
  - stimulus: queue holds 0x0000_1234; ready=1; beats D0..D3 with last on D3.
  - response: mem_req_addr=0x0000_1200; line_wr_data={D3,D2,D1,D0}; line_wr_addr=0x0000_1200; one line_wr_valid pulse; err_last=0.
- Request backpressure:
  - stimulus: mem_req_ready held 0 for 5 cycles.
  - response: mem_req_valid stays 1 with a stable address; no beat is stored before acceptance.
- Gapped beats:
  - stimulus: beats arrive with 0-3 idle cycles between them.
  - response: correct slot ordering; line_wr_valid exactly 1 cycle after the 4th beat.
- Duplicate filter:
  - stimulus: back-to-back entries 0x2040 then 0x207C.
  - response: one memory request only; the second entry is popped and dropped; busy returns to 0.
- Last-marker error:
  - stimulus: mem_rsp_last asserted on beat 2.
  - response: err_last pulses once; the line is still written after beat 3.
- Reset mid-BEAT:
  - stimulus: rst_n asserted after beat 1.
  - response: all outputs 0 immediately; after release, a new miss 0x4000 refills cleanly, with no duplicate suppression carried over.

Source files
------------

// File: rtl/icache_refill_ctrl_if.sv
// Bundle of miss-queue, memory burst and line-write signals for the icache refill controller.
// The controller side uses master and the queue/memory/cache side uses slave.
interface icache_refill_ctrl_if #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned LINE_BYTES = 64,
  parameter int unsigned BUS_W      = 128
);
  localparam int unsigned LINE_W = LINE_BYTES * 8;

  logic              q_empty;
  logic              q_rd_en;
  logic [ADDR_W-1:0] q_data;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_rsp_valid;
  logic [BUS_W-1:0]  mem_rsp_data;
  logic              mem_rsp_last;

  logic              line_wr_valid;
  logic [ADDR_W-1:0] line_wr_addr;
  logic [LINE_W-1:0] line_wr_data;

  logic              busy;
  logic              err_last;

  modport master (
    input  q_empty, q_data, mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_last,
    output q_rd_en, mem_req_valid, mem_req_addr, line_wr_valid, line_wr_addr, line_wr_data,
           busy, err_last
  );

  modport slave (
    output q_empty, q_data, mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_last,
    input  q_rd_en, mem_req_valid, mem_req_addr, line_wr_valid, line_wr_addr, line_wr_data,
           busy, err_last
  );
endinterface

// File: rtl/icache_refill_ctrl.sv
// Icache refill controller: pops one miss address at a time, bursts the line from memory,
// assembles the beats and issues a single-cycle line write. Repeat misses to the last line are dropped.
module icache_refill_ctrl #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned LINE_BYTES = 64,
  parameter int unsigned BUS_W      = 128
) (
  input logic                 clk,
  input logic                 rst_n,
  icache_refill_ctrl_if.master bus
);
  localparam int unsigned LINE_W = LINE_BYTES * 8;
  localparam int unsigned BEATS  = LINE_W / BUS_W;
  localparam int unsigned OFS_W  = $clog2(LINE_BYTES);
  localparam int unsigned BCNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(BEATS - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W - OFS_W){1'b1}}, {OFS_W{1'b0}}};

  typedef enum logic [2:0] {IDLE, LATCH, REQ, BEAT, WRITE} state_e;

  state_e              state_q, state_d;
  logic [BCNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [LINE_W-1:0]   line_buf_q, line_buf_d;
  logic [ADDR_W-1:0]   line_addr_q, line_addr_d;
  logic [ADDR_W-1:0]   last_line_addr_q, last_line_addr_d;
  logic                last_line_vld_q, last_line_vld_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [LINE_W-1:0]   wr_data_q, wr_data_d;
  logic                err_last_q, err_last_d;
  logic [ADDR_W-1:0]   q_line_addr;
  logic                final_beat;

  assign q_line_addr = bus.q_data & LINE_MASK;
  assign final_beat  = (beat_cnt_q == LAST_BEAT);

  always_comb begin
    state_d          = state_q;
    beat_cnt_d       = beat_cnt_q;
    line_buf_d       = line_buf_q;
    line_addr_d      = line_addr_q;
    last_line_addr_d = last_line_addr_q;
    last_line_vld_d  = last_line_vld_q;
    wr_addr_d        = wr_addr_q;
    wr_data_d        = wr_data_q;
    err_last_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!bus.q_empty) state_d = LATCH;
      end
      LATCH: begin
        line_addr_d = q_line_addr;
        if (last_line_vld_q && (q_line_addr == last_line_addr_q)) state_d = IDLE;
        else                                                       state_d = REQ;
      end
      REQ: begin
        if (bus.mem_req_ready) begin
          beat_cnt_d = '0;
          state_d    = BEAT;
        end
      end
      BEAT: begin
        if (bus.mem_rsp_valid) begin
          line_buf_d[int'(beat_cnt_q) * BUS_W +: BUS_W] = bus.mem_rsp_data;
          err_last_d = (bus.mem_rsp_last != final_beat);
          if (final_beat) begin
            // Output copies are loaded here so the write port holds steady while the
            // assembly buffer is reused by the next burst.
            beat_cnt_d = '0;
            wr_addr_d  = line_addr_q;
            wr_data_d  = line_buf_d;
            state_d    = WRITE;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      WRITE: begin
        last_line_addr_d = line_addr_q;
        last_line_vld_d  = 1'b1;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      beat_cnt_q       <= '0;
      line_buf_q       <= '0;
      line_addr_q      <= '0;
      last_line_addr_q <= '0;
      last_line_vld_q  <= 1'b0;
      wr_addr_q        <= '0;
      wr_data_q        <= '0;
      err_last_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      beat_cnt_q       <= beat_cnt_d;
      line_buf_q       <= line_buf_d;
      line_addr_q      <= line_addr_d;
      last_line_addr_q <= last_line_addr_d;
      last_line_vld_q  <= last_line_vld_d;
      wr_addr_q        <= wr_addr_d;
      wr_data_q        <= wr_data_d;
      err_last_q       <= err_last_d;
    end
  end

  // Pop is combinational from IDLE; gating with rst_n keeps it low while reset is held.
  assign bus.q_rd_en       = rst_n && (state_q == IDLE) && !bus.q_empty;
  assign bus.mem_req_valid = (state_q == REQ);
  assign bus.mem_req_addr  = line_addr_q;
  assign bus.line_wr_valid = (state_q == WRITE);
  assign bus.line_wr_addr  = wr_addr_q;
  assign bus.line_wr_data  = wr_data_q;
  assign bus.busy          = (state_q != IDLE);
  assign bus.err_last      = err_last_q;
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl: queue and memory models driven from tables, with a
// per-cycle compare against expected line writes and error pulses.
module tb_icache_refill_ctrl;
  localparam int ADDR_W     = 32;
  localparam int LINE_BYTES = 64;
  localparam int BUS_W      = 128;
  localparam int LINE_W     = LINE_BYTES * 8;

  typedef logic [3:0][BUS_W-1:0] beats_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  icache_refill_ctrl_if #(.ADDR_W(ADDR_W), .LINE_BYTES(LINE_BYTES), .BUS_W(BUS_W)) bus ();

  icache_refill_ctrl #(.ADDR_W(ADDR_W), .LINE_BYTES(LINE_BYTES), .BUS_W(BUS_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Miss-queue model: data appears the cycle after a pop.
  logic [ADDR_W-1:0] fifo_mem [32];
  int push_cnt = 0;
  int pop_cnt  = 0;
  assign bus.q_empty = (push_cnt == pop_cnt);
  always @(posedge clk) begin
    if (rst_n && bus.q_rd_en) begin
      bus.q_data <= fifo_mem[pop_cnt % 32];
      pop_cnt    <= pop_cnt + 1;
    end
  end

  // Expected events, appended by the stimulus and consumed by the compare process.
  int                exp_wr_cyc  [16];
  logic [ADDR_W-1:0] exp_wr_addr [16];
  logic [LINE_W-1:0] exp_wr_data [16];
  int                wr_n = 0;
  int                err_cyc [16];
  int                err_n = 0;
  bit                mon_en = 1'b0;

  int                wr_idx = 0;
  int                err_idx = 0;
  int                last_pop_cyc = -100;
  logic [ADDR_W-1:0] held_addr = '0;
  logic [LINE_W-1:0] held_data = '0;
  logic              prev_rd = 1'b0;
  logic              exp_v;

  function automatic void chk1(input string nm, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b (cycle %0d)", nm, got, exp, cyc);
    end
  endfunction

  function automatic void chk32(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", nm, got, exp, cyc);
    end
  endfunction

  function automatic void chkw(input string nm, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, got, exp, cyc);
    end
  endfunction

  function automatic beats_t mk_beats(input logic [7:0] tag);
    beats_t b;
    for (int i = 0; i < 4; i++) b[i] = {tag, 8'(i), {14{tag ^ 8'(i * 37 + 1)}}};
    return b;
  endfunction

  // Per-cycle compare against the expected-event lists.
  initial begin : compare
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held_addr = '0;
        held_data = '0;
        prev_rd   = 1'b0;
      end else if (mon_en) begin
        if (bus.q_rd_en) begin
          last_pop_cyc = cyc;
          chk1("q_rd_en_single_cycle", prev_rd, 1'b0);
        end
        prev_rd = bus.q_rd_en;

        exp_v = (wr_idx < wr_n) && (exp_wr_cyc[wr_idx] == cyc);
        chk1("line_wr_valid", bus.line_wr_valid, exp_v);
        if (exp_v) begin
          held_addr = exp_wr_addr[wr_idx];
          held_data = exp_wr_data[wr_idx];
          wr_idx++;
        end else if ((wr_idx < wr_n) && (exp_wr_cyc[wr_idx] < cyc)) begin
          wr_idx++;
        end
        chk32("line_wr_addr", bus.line_wr_addr, held_addr);
        chkw("line_wr_data", bus.line_wr_data, held_data);

        exp_v = (err_idx < err_n) && (err_cyc[err_idx] == cyc);
        chk1("err_last", bus.err_last, exp_v);
        if (exp_v) err_idx++;
        else if ((err_idx < err_n) && (err_cyc[err_idx] < cyc)) err_idx++;

        if (bus.mem_req_valid)
          chk32("mem_req_addr_aligned", bus.mem_req_addr & 32'h0000_003F, 32'h0);
        if (bus.mem_req_valid || bus.line_wr_valid)
          chk1("busy_when_active", bus.busy, 1'b1);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [ADDR_W-1:0] a);
    fifo_mem[push_cnt % 32] = a;
    push_cnt++;
  endtask

  task automatic check_zero(input string tag);
    chk1({tag, "_q_rd_en"}, bus.q_rd_en, 1'b0);
    chk1({tag, "_mem_req_valid"}, bus.mem_req_valid, 1'b0);
    chk32({tag, "_mem_req_addr"}, bus.mem_req_addr, 32'h0);
    chk1({tag, "_line_wr_valid"}, bus.line_wr_valid, 1'b0);
    chk32({tag, "_line_wr_addr"}, bus.line_wr_addr, 32'h0);
    chkw({tag, "_line_wr_data"}, bus.line_wr_data, '0);
    chk1({tag, "_busy"}, bus.busy, 1'b0);
    chk1({tag, "_err_last"}, bus.err_last, 1'b0);
  endtask

  // One refill: wait for the request, optionally stall it, then deliver four beats.
  task automatic refill(input logic [ADDR_W-1:0] exp_addr, input beats_t d,
                        input logic [3:0][1:0] gaps, input logic [3:0] last_mask,
                        input int stall, input bit junk, input int abort_after);
    int n;
    logic [LINE_W-1:0] line;
    line = '0;
    n = 0;
    while (!bus.mem_req_valid && n < 40) begin
      tick;
      n++;
    end
    if (!bus.mem_req_valid) begin
      chk1("mem_req_valid_timeout", bus.mem_req_valid, 1'b1);
      return;
    end
    chk32("req_latency_from_pop", 32'(cyc - last_pop_cyc), 32'd2);
    chk32("mem_req_addr", bus.mem_req_addr, exp_addr);

    for (int s = 0; s < stall; s++) begin
      bus.mem_req_ready = 1'b0;
      bus.mem_rsp_valid = junk;
      bus.mem_rsp_data  = 128'hBAD0_0000_0000_0000_0000_0000_0000_0000 | 128'(s);
      bus.mem_rsp_last  = 1'b0;
      tick;
      chk1("req_hold_valid", bus.mem_req_valid, 1'b1);
      chk32("req_hold_addr", bus.mem_req_addr, exp_addr);
    end
    bus.mem_req_ready = 1'b1;
    bus.mem_rsp_valid = junk;
    bus.mem_rsp_data  = 128'hBAD1_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;
    tick;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    chk1("req_drops_after_accept", bus.mem_req_valid, 1'b0);

    for (int i = 0; i < 4; i++) begin
      repeat (gaps[i]) begin
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = 128'hBAD2_0000_0000_0000_0000_0000_0000_0000 | 128'(cyc);
        bus.mem_rsp_last  = 1'b1;
        tick;
      end
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = d[i];
      bus.mem_rsp_last  = last_mask[i];
      line[i * BUS_W +: BUS_W] = d[i];
      if (last_mask[i] != (i == 3)) begin
        err_cyc[err_n] = cyc + 1;
        err_n++;
      end
      if (i == 3) begin
        exp_wr_cyc[wr_n]  = cyc + 1;
        exp_wr_addr[wr_n] = exp_addr;
        exp_wr_data[wr_n] = line;
        wr_n++;
      end
      tick;
      if (i == abort_after) begin
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_last  = 1'b0;
        return;
      end
    end
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_last  = 1'b0;
    chk1("line_wr_valid_after_final_beat", bus.line_wr_valid, 1'b1);
    chk1("busy_in_write", bus.busy, 1'b1);
    tick;
    chk1("line_wr_valid_one_cycle", bus.line_wr_valid, 1'b0);
    chk1("busy_after_write", bus.busy, 1'b0);
  endtask

  localparam logic [BUS_W-1:0] D0 = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
  localparam logic [BUS_W-1:0] D1 = 128'h1020_3040_5060_7080_90A0_B0C0_D0E0_F000;
  localparam logic [BUS_W-1:0] D2 = 128'hDEAD_BEEF_0000_0002_CAFE_F00D_2222_2222;
  localparam logic [BUS_W-1:0] D3 = 128'h0BAD_C0DE_3333_3333_FEED_FACE_0000_0003;

  initial begin : stimulus
    beats_t t1;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
    bus.mem_rsp_last  = 1'b0;
    t1 = {D3, D2, D1, D0};

    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n  = 1'b1;
    mon_en = 1'b1;
    tick;

    // Single miss
    push(32'h0000_1234);
    refill(32'h0000_1200, t1, '0, 4'b1000, 0, 1'b0, -1);
    chk32("single_wr_addr_literal", bus.line_wr_addr, 32'h0000_1200);
    chkw("single_wr_data_literal", bus.line_wr_data,
         {128'h0BAD_C0DE_3333_3333_FEED_FACE_0000_0003, 128'hDEAD_BEEF_0000_0002_CAFE_F00D_2222_2222,
          128'h1020_3040_5060_7080_90A0_B0C0_D0E0_F000, 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF});

    // Request backpressure with stray beats before acceptance
    push(32'h8000_0047);
    refill(32'h8000_0040, mk_beats(8'h22), '0, 4'b1000, 5, 1'b1, -1);

    // Gapped beats: gaps 2,0,3,1 before beats 0..3
    push(32'h0000_3FFF);
    refill(32'h0000_3FC0, mk_beats(8'h33), {2'd1, 2'd3, 2'd0, 2'd2}, 4'b1000, 1, 1'b0, -1);

    // Duplicate filter
    push(32'h0000_2040);
    push(32'h0000_207C);
    refill(32'h0000_2040, mk_beats(8'h44), '0, 4'b1000, 0, 1'b0, -1);
    chk1("dup_pop_two_after_final", bus.q_rd_en, 1'b1);
    for (int c = 0; c < 8; c++) begin
      tick;
      chk1("dup_no_mem_req", bus.mem_req_valid, 1'b0);
    end
    chk1("dup_busy_idle", bus.busy, 1'b0);
    chk32("dup_entry_popped", 32'(pop_cnt), 32'(push_cnt));

    // Last-marker error on beat 2 (last also on beat 3, so exactly one pulse)
    push(32'h0000_5010);
    refill(32'h0000_5000, mk_beats(8'h55), {2'd0, 2'd1, 2'd0, 2'd0}, 4'b1100, 0, 1'b0, -1);
    // Missing last marker on the final beat
    push(32'h0000_6000);
    refill(32'h0000_6000, mk_beats(8'h66), '0, 4'b0000, 0, 1'b0, -1);

    // Reset in the middle of a burst, after beat 1
    push(32'h0000_4000);
    refill(32'h0000_4000, mk_beats(8'h77), '0, 4'b1000, 0, 1'b0, 1);
    rst_n = 1'b0;
    #1;
    check_zero("reset_mid_beat");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick;
    push(32'h0000_6008);
    refill(32'h0000_6000, mk_beats(8'h88), '0, 4'b1000, 0, 1'b0, -1);
    push(32'h0000_4000);
    refill(32'h0000_4000, mk_beats(8'h99), {2'd0, 2'd2, 2'd0, 2'd1}, 4'b1000, 2, 1'b1, -1);

    repeat (4) tick;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got time %0t, expected under 200000", $time);
    $fatal(1);
  end
endmodule
